// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Puts one CPU port and NLD loader write ports onto a single-port RAM.
//   A clear engine fills the RAM with CLR_VAL after reset (optional) or on
//   clear_req. During a sweep, CPU and loader requests are held off.
//   Port summary:
//     clk, reset_n               clock, async active-low reset
//     clear_req / clear_busy     start a sweep / sweep in progress
//     cpu_*                      CPU access port (highest priority)
//     cpu_q                      read data, straight from mem_q
//     cpu_wait                   CPU access sampled this cycle was not served
//     ld_req/ld_addr/ld_din      packed loader write requests
//     ld_ack                     one-cycle grant pulse per loader
//     mem_*                      registered RAM interface
module ram_port_arbiter #(
  parameter int              AW           = 16,
  parameter int              DW           = 8,
  parameter int              NLD          = 2,
  parameter logic [DW-1:0]   CLR_VAL      = {DW{1'b1}},
  parameter bit              CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_din,
  output logic [DW-1:0]     cpu_q,
  output logic              cpu_wait,
  input  logic [NLD-1:0]    ld_req,
  input  logic [NLD*AW-1:0] ld_addr,
  input  logic [NLD*DW-1:0] ld_din,
  output logic [NLD-1:0]    ld_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_q
);

  localparam int PW = (NLD > 1) ? $clog2(NLD) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NLD - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;
  localparam state_t ST_RST = CLR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_inc;
  logic [PW-1:0] r_ptr;
  logic          r_mem_cs;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_din;
  logic [NLD-1:0] r_ld_ack;
  logic          r_cpu_wait;
  logic          r_clear_busy;

  logic [NLD-1:0] w_elig;
  logic           w_gnt_found;
  int             w_gnt_idx;
  int             w_best_dist;
  int             w_dist;
  logic [NLD-1:0] w_gnt_oh;

  logic           w_mem_cs_nxt;
  logic           w_mem_we_nxt;
  logic [AW-1:0]  w_mem_addr_nxt;
  logic [DW-1:0]  w_mem_din_nxt;
  logic [NLD-1:0] w_ld_ack_nxt;
  logic           w_cpu_wait_nxt;
  logic [AW:0]    w_cnt_nxt;
  logic [PW-1:0]  w_ptr_nxt;

  // Counter is one bit wider than the address so its MSB flags the last write.
  assign w_cnt_inc = r_cnt + {{AW{1'b0}}, 1'b1};

  // A loader being acked right now is masked so a registered loader can drop
  // its request one cycle late without getting a second write.
  assign w_elig = ld_req & ~r_ld_ack;

  assign cpu_q      = mem_q;
  assign mem_cs     = r_mem_cs;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign ld_ack     = r_ld_ack;
  assign cpu_wait   = r_cpu_wait;
  assign clear_busy = r_clear_busy;

  // Round-robin pick: smallest distance from pointer+1 (wrapping) wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = 0;
    w_best_dist = NLD;
    w_dist      = 0;
    for (int i = 0; i < NLD; i++) begin
      w_dist      = (i + NLD - 1 - int'(r_ptr)) % NLD;
      w_gnt_found = (w_elig[i] && (w_dist < w_best_dist)) ? 1'b1 : w_gnt_found;
      w_gnt_idx   = (w_elig[i] && (w_dist < w_best_dist)) ? i : w_gnt_idx;
      w_best_dist = (w_elig[i] && (w_dist < w_best_dist)) ? w_dist : w_best_dist;
    end
    for (int i = 0; i < NLD; i++) begin
      w_gnt_oh[i] = w_gnt_found && (i == w_gnt_idx);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a sweep ends when the counter carries into its MSB.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (w_cnt_inc[AW]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  // Output logic: next values of every registered output and datapath reg.
  always_comb begin
    w_mem_cs_nxt   = 1'b0;
    w_mem_we_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_din_nxt  = r_mem_din;
    w_ld_ack_nxt   = {NLD{1'b0}};
    w_cpu_wait_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_ptr_nxt      = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_mem_cs_nxt   = 1'b1;
        w_mem_we_nxt   = 1'b1;
        w_mem_addr_nxt = r_cnt[AW-1:0];
        w_mem_din_nxt  = CLR_VAL;
        w_cnt_nxt      = w_cnt_inc;
        w_cpu_wait_nxt = cpu_cs;
      end
      ST_RUN: begin
        // The access sampled alongside clear_req is still served.
        if (clear_req) begin
          w_cnt_nxt = {(AW+1){1'b0}};
        end else begin
          w_cnt_nxt = r_cnt;
        end
        if (cpu_cs) begin
          w_mem_cs_nxt   = 1'b1;
          w_mem_we_nxt   = cpu_we;
          w_mem_addr_nxt = cpu_addr;
          w_mem_din_nxt  = cpu_din;
        end else if (w_gnt_found) begin
          w_mem_cs_nxt   = 1'b1;
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = ld_addr[w_gnt_idx*AW +: AW];
          w_mem_din_nxt  = ld_din[w_gnt_idx*DW +: DW];
          w_ld_ack_nxt   = w_gnt_oh;
          w_ptr_nxt      = w_gnt_idx[PW-1:0];
        end else begin
          w_mem_cs_nxt = 1'b0;
          w_mem_we_nxt = 1'b0;
        end
      end
      default: begin
        w_mem_cs_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs, clear counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {AW{1'b0}};
      r_mem_din    <= {DW{1'b0}};
      r_ld_ack     <= {NLD{1'b0}};
      r_cpu_wait   <= 1'b0;
      r_cnt        <= {(AW+1){1'b0}};
      r_ptr        <= PTR_RST;
      r_clear_busy <= CLR_ON_RESET;
    end else begin
      r_mem_cs     <= w_mem_cs_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_din    <= w_mem_din_nxt;
      r_ld_ack     <= w_ld_ack_nxt;
      r_cpu_wait   <= w_cpu_wait_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ptr        <= w_ptr_nxt;
      r_clear_busy <= (w_state_nxt == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with AW=4, DW=8, NLD=2, CLR_VAL=0xFF.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_req;
  logic        clear_busy;
  logic        cpu_cs;
  logic        cpu_we;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_q;
  logic        cpu_wait;
  logic [1:0]  ld_req;
  logic [7:0]  ld_addr;
  logic [15:0] ld_din;
  logic [1:0]  ld_ack;
  logic        mem_cs;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_q = 8'h00;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [16];
  int nwr = 0;

  ram_port_arbiter #(.AW(4), .DW(8), .NLD(2), .CLR_VAL(8'hFF), .CLR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_q(cpu_q), .cpu_wait(cpu_wait), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_din(ld_din), .ld_ack(ld_ack), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with registered read data.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_din;
        nwr <= nwr + 1;
      end else begin
        mem_q <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_cs"}, mem_cs, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 4'h0);
    chk({tag, "_mem_din"}, mem_din, 8'h00);
    chk({tag, "_ld_ack"}, ld_ack, 2'b00);
    chk({tag, "_cpu_wait"}, cpu_wait, 1'b0);
    chk({tag, "_clear_busy"}, clear_busy, 1'b1);
  endtask

  typedef struct {
    logic       cpu_cs;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [1:0] ld_req;
    logic       e_cs;
    logic       e_we;
    logic [3:0] e_addr;
    logic [7:0] e_din;
    logic [1:0] e_ack;
    logic       chk_q;
    logic [7:0] e_q;
  } vec_t;

  vec_t vt [15];
  int   wsave;

  initial begin
    // Loader 0 writes 0xA0 to 0xA, loader 1 writes 0xB1 to 0xB.
    vt[0]  = '{1'b1, 1'b1, 4'h3, 8'h5A, 2'b00, 1'b1, 1'b1, 4'h3, 8'h5A, 2'b00, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 4'h3, 8'h00, 2'b00, 1'b1, 1'b0, 4'h3, 8'h00, 2'b00, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b00, 1'b0, 1'b0, 4'h3, 8'h00, 2'b00, 1'b1, 8'h5A};
    vt[3]  = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b11, 1'b1, 1'b1, 4'hA, 8'hA0, 2'b01, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b11, 1'b1, 1'b1, 4'hB, 8'hB1, 2'b10, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b11, 1'b1, 1'b1, 4'hA, 8'hA0, 2'b01, 1'b0, 8'h00};
    vt[6]  = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b11, 1'b1, 1'b1, 4'hB, 8'hB1, 2'b10, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b1, 4'h7, 8'h11, 2'b01, 1'b1, 1'b1, 4'h7, 8'h11, 2'b00, 1'b0, 8'h00};
    vt[8]  = '{1'b1, 1'b0, 4'h7, 8'h22, 2'b01, 1'b1, 1'b0, 4'h7, 8'h22, 2'b00, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b01, 1'b1, 1'b1, 4'hA, 8'hA0, 2'b01, 1'b1, 8'h11};
    vt[10] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b01, 1'b0, 1'b0, 4'hA, 8'hA0, 2'b00, 1'b0, 8'h00};
    vt[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b01, 1'b1, 1'b1, 4'hA, 8'hA0, 2'b01, 1'b0, 8'h00};
    vt[12] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b00, 1'b0, 1'b0, 4'hA, 8'hA0, 2'b00, 1'b0, 8'h00};
    vt[13] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b10, 1'b1, 1'b1, 4'hB, 8'hB1, 2'b10, 1'b0, 8'h00};
    vt[14] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'b00, 1'b0, 1'b0, 4'hB, 8'hB1, 2'b00, 1'b0, 8'h00};

    clear_req = 1'b0;
    cpu_cs    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 4'h0;
    cpu_din   = 8'h00;
    ld_req    = 2'b00;
    ld_addr   = {4'hB, 4'hA};
    ld_din    = {8'hB1, 8'hA0};
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_no_write", nwr, 0);

    // Power-on sweep with CPU and loaders knocking.
    cpu_cs   = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 4'h5;
    cpu_din  = 8'h33;
    ld_req   = 2'b11;
    reset_n  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("sweep0_cs_%0d", k), mem_cs, 1'b1);
      chk($sformatf("sweep0_we_%0d", k), mem_we, 1'b1);
      chk($sformatf("sweep0_addr_%0d", k), mem_addr, k - 1);
      chk($sformatf("sweep0_din_%0d", k), mem_din, 8'hFF);
      chk($sformatf("sweep0_wait_%0d", k), cpu_wait, 1'b1);
      chk($sformatf("sweep0_ack_%0d", k), ld_ack, 2'b00);
      chk($sformatf("sweep0_busy_%0d", k), clear_busy, (k < 16) ? 1'b1 : 1'b0);
    end
    cpu_cs = 1'b0;
    ld_req = 2'b00;
    step();
    chk("sweep0_end_cs", mem_cs, 1'b0);
    chk("sweep0_end_wait", cpu_wait, 1'b0);
    chk("sweep0_end_busy", clear_busy, 1'b0);
    chk("sweep0_nwr", nwr, 16);
    for (int a = 0; a < 16; a++) begin
      chk($sformatf("sweep0_ram_%0d", a), ram[a], 8'hFF);
    end

    // Table-driven RUN-state vectors.
    for (int i = 0; i < 15; i++) begin
      cpu_cs   = vt[i].cpu_cs;
      cpu_we   = vt[i].cpu_we;
      cpu_addr = vt[i].cpu_addr;
      cpu_din  = vt[i].cpu_din;
      ld_req   = vt[i].ld_req;
      step();
      chk($sformatf("vec%0d_cs", i), mem_cs, vt[i].e_cs);
      chk($sformatf("vec%0d_we", i), mem_we, vt[i].e_we);
      chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_din", i), mem_din, vt[i].e_din);
      chk($sformatf("vec%0d_ack", i), ld_ack, vt[i].e_ack);
      chk($sformatf("vec%0d_wait", i), cpu_wait, 1'b0);
      if (vt[i].chk_q) begin
        chk($sformatf("vec%0d_cpu_q", i), cpu_q, vt[i].e_q);
      end
    end
    chk("ram_3", ram[3], 8'h5A);
    chk("ram_7", ram[7], 8'h11);
    chk("ram_a", ram[10], 8'hA0);
    chk("ram_b", ram[11], 8'hB1);

    // clear_req together with a CPU write: the write lands, then the sweep.
    clear_req = 1'b1;
    cpu_cs    = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'h2;
    cpu_din   = 8'h77;
    step();
    chk("clr_cpu_cs", mem_cs, 1'b1);
    chk("clr_cpu_we", mem_we, 1'b1);
    chk("clr_cpu_addr", mem_addr, 4'h2);
    chk("clr_cpu_din", mem_din, 8'h77);
    chk("clr_cpu_wait", cpu_wait, 1'b0);
    chk("clr_busy_rise", clear_busy, 1'b1);
    cpu_cs = 1'b0;
    ld_req = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      clear_req = (k == 6) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("sweep1_addr_%0d", k), mem_addr, k - 1);
      chk($sformatf("sweep1_din_%0d", k), mem_din, 8'hFF);
      chk($sformatf("sweep1_we_%0d", k), mem_we, 1'b1);
      chk($sformatf("sweep1_ack_%0d", k), ld_ack, 2'b00);
      chk($sformatf("sweep1_busy_%0d", k), clear_busy, (k < 16) ? 1'b1 : 1'b0);
      if (k == 1) begin
        chk("sweep1_ram2_77", ram[2], 8'h77);
      end
    end
    clear_req = 1'b0;
    ld_req    = 2'b00;
    step();
    chk("sweep1_end_busy", clear_busy, 1'b0);
    chk("sweep1_end_cs", mem_cs, 1'b0);
    cpu_cs = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 4'h2;
    step();
    cpu_cs = 1'b0;
    step();
    chk("sweep1_read2", cpu_q, 8'hFF);

    // Reset in the middle of a sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (8) step();
    chk("midrst_addr7", mem_addr, 4'h7);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    wsave = nwr;
    step();
    step();
    chk("midrst_no_write", nwr, wsave);
    reset_n = 1'b1;
    step();
    chk("midrst_restart_cs", mem_cs, 1'b1);
    chk("midrst_restart_addr", mem_addr, 4'h0);
    chk("midrst_restart_busy", clear_busy, 1'b1);
    repeat (15) step();
    chk("midrst_last_addr", mem_addr, 4'hF);
    chk("midrst_end_busy", clear_busy, 1'b0);
    step();
    chk("midrst_idle_cs", mem_cs, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
